// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: keyframe colour sequencer feeding the RGB PWM duty
// comparators. Linearly fades from the current colour to each keyframe of a
// small writable table, holds it, then moves on and wraps at last_key.
// Optional build macro: RGB_FADE_GAMMA_EN adds a registered square-law gamma
// stage on the duty outputs (one extra clock of latency on the duties only).
module rgb_fade_sequencer #(
  parameter int CLK_FREQ_HZ = 12_000_000,
  parameter int STEP_HZ     = 256,
  parameter int NUM_KEYS    = 8,
  parameter int FADE_STEPS  = 64,
  parameter int HOLD_STEPS  = 128
) (
  input  logic                        clk,
  input  logic                        SW,
  input  logic                        run,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_KEYS)-1:0] wr_addr,
  input  logic [23:0]                 wr_data,
  input  logic [$clog2(NUM_KEYS)-1:0] last_key,
  output logic [7:0]                  red_val,
  output logic [7:0]                  green_val,
  output logic [7:0]                  blue_val,
  output logic [$clog2(NUM_KEYS)-1:0] key_idx,
  output logic [1:0]                  state,
  output logic                        seq_wrap
);

  localparam int STEP_DIV = CLK_FREQ_HZ / STEP_HZ;
  localparam int PW       = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int KW       = $clog2(NUM_KEYS);
  localparam int FW       = $clog2(FADE_STEPS);
  localparam int CW       = FW + 1;
  localparam int HW       = $clog2(HOLD_STEPS + 1);
  localparam int PRW      = FW + 11;

  localparam logic [PW-1:0] STEP_LAST  = PW'(STEP_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [KW-1:0] KEY_ONE    = KW'(1);
  localparam logic [KW-1:0] KEY_ZERO   = KW'(0);
  localparam logic [CW-1:0] STEP_ONE   = CW'(1);
  localparam logic [CW-1:0] STEP_ZERO  = CW'(0);
  localparam logic [CW-1:0] STEP_END   = CW'(FADE_STEPS);
  localparam logic [HW-1:0] HOLD_ONE   = HW'(1);
  localparam logic [HW-1:0] HOLD_ZERO  = HW'(0);
  localparam logic [HW-1:0] HOLD_END   = HW'(HOLD_STEPS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FADE = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // One channel of the interpolator: start + floor((target-start)*k / FADE_STEPS).
  // The difference is 10-bit signed so a falling fade floors toward -inf.
  function automatic logic [7:0] interp(input logic [7:0] s, input logic [7:0] t,
                                        input logic [CW-1:0] k);
    logic signed [9:0]     d;
    logic signed [PRW-1:0] de;
    logic signed [PRW-1:0] ke;
    logic signed [PRW-1:0] p;
    logic signed [PRW-1:0] sum;
    d   = $signed({2'b00, t}) - $signed({2'b00, s});
    de  = {{(PRW-10){d[9]}}, d};
    ke  = {{(PRW-CW){1'b0}}, k};
    p   = (de * ke) >>> FW;
    sum = p + $signed({{(PRW-8){1'b0}}, s});
    return sum[7:0];
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_presc;
  logic [CW-1:0]   r_step_cnt;
  logic [CW-1:0]   w_step_nxt;
  logic [CW-1:0]   w_step_inc;
  logic [HW-1:0]   r_hold_cnt;
  logic [HW-1:0]   w_hold_nxt;
  logic [HW-1:0]   w_hold_inc;
  logic [KW-1:0]   r_key_idx;
  logic [KW-1:0]   w_key_nxt;
  logic [KW-1:0]   w_key_adv;
  logic [23:0]     r_start;
  logic [23:0]     w_start_nxt;
  logic [23:0]     r_target;
  logic [23:0]     w_target_nxt;
  logic [23:0]     r_duty;
  logic [23:0]     w_duty_nxt;
  logic            r_seq_wrap;
  logic            w_wrap_nxt;
  logic            w_active;
  logic            w_tick;
  logic            w_wraps;
  logic [23:0]     r_table [NUM_KEYS];

  assign w_active   = run & (r_state != ST_IDLE);
  assign w_tick     = w_active & (r_presc == STEP_LAST);
  assign w_step_inc = r_step_cnt + STEP_ONE;
  assign w_hold_inc = r_hold_cnt + HOLD_ONE;
  assign w_wraps    = (r_key_idx >= last_key);
  assign w_key_adv  = w_wraps ? KEY_ZERO : (r_key_idx + KEY_ONE);

  // Step-rate prescaler; frozen while paused or idle so resume is exact.
  always_ff @(posedge clk or negedge SW) begin
    if (!SW) begin
      r_presc <= '0;
    end else if (w_active) begin
      r_presc <= w_tick ? '0 : (r_presc + PRESC_ONE);
    end
  end

  // Keyframe table with its power-on colours; writes land regardless of state.
  always_ff @(posedge clk or negedge SW) begin
    if (!SW) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_table[i] <= 24'h000000;
      end
      r_table[0] <= 24'hFF0000;
      r_table[1] <= 24'h00FF00;
      r_table[2] <= 24'h0000FF;
    end else if (wr_en) begin
      r_table[wr_addr] <= wr_data;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge SW) begin
    if (!SW) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath decisions; all values hold unless a step tick acts.
  always_comb begin
    w_state_nxt  = r_state;
    w_step_nxt   = r_step_cnt;
    w_hold_nxt   = r_hold_cnt;
    w_key_nxt    = r_key_idx;
    w_start_nxt  = r_start;
    w_target_nxt = r_target;
    w_duty_nxt   = r_duty;
    w_wrap_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run) begin
          w_state_nxt  = ST_FADE;
          w_start_nxt  = r_duty;
          w_target_nxt = r_table[r_key_idx];
          w_step_nxt   = STEP_ZERO;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_FADE: begin
        if (w_tick) begin
          w_step_nxt = w_step_inc;
          w_duty_nxt = {interp(r_start[23:16], r_target[23:16], w_step_inc),
                        interp(r_start[15:8],  r_target[15:8],  w_step_inc),
                        interp(r_start[7:0],   r_target[7:0],   w_step_inc)};
          if (w_step_inc == STEP_END) begin
            w_state_nxt = ST_HOLD;
            w_hold_nxt  = HOLD_ZERO;
          end else begin
            w_state_nxt = ST_FADE;
          end
        end else begin
          w_state_nxt = ST_FADE;
        end
      end
      ST_HOLD: begin
        if (w_tick) begin
          if (w_hold_inc == HOLD_END) begin
            w_key_nxt    = w_key_adv;
            w_wrap_nxt   = w_wraps;
            w_start_nxt  = r_duty;
            w_target_nxt = r_table[w_key_adv];
            w_step_nxt   = STEP_ZERO;
            w_state_nxt  = ST_FADE;
          end else begin
            w_hold_nxt   = w_hold_inc;
          end
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath registers: counters, key index, fade endpoints, duties, wrap pulse.
  always_ff @(posedge clk or negedge SW) begin
    if (!SW) begin
      r_step_cnt <= '0;
      r_hold_cnt <= '0;
      r_key_idx  <= '0;
      r_start    <= 24'h000000;
      r_target   <= 24'h000000;
      r_duty     <= 24'h000000;
      r_seq_wrap <= 1'b0;
    end else begin
      r_step_cnt <= w_step_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_key_idx  <= w_key_nxt;
      r_start    <= w_start_nxt;
      r_target   <= w_target_nxt;
      r_duty     <= w_duty_nxt;
      r_seq_wrap <= w_wrap_nxt;
    end
  end

`ifdef RGB_FADE_GAMMA_EN
  // Square-law gamma: top byte of v*v per channel.
  function automatic logic [7:0] gamma(input logic [7:0] v);
    logic [15:0] sq;
    sq = {8'h00, v} * {8'h00, v};
    return sq[15:8];
  endfunction

  logic [23:0] r_gamma;

  // Registered gamma stage on the duties.
  always_ff @(posedge clk or negedge SW) begin
    if (!SW) begin
      r_gamma <= 24'h000000;
    end else begin
      r_gamma <= {gamma(r_duty[23:16]), gamma(r_duty[15:8]), gamma(r_duty[7:0])};
    end
  end

  assign red_val   = r_gamma[23:16];
  assign green_val = r_gamma[15:8];
  assign blue_val  = r_gamma[7:0];
`else
  assign red_val   = r_duty[23:16];
  assign green_val = r_duty[15:8];
  assign blue_val  = r_duty[7:0];
`endif

  assign key_idx  = r_key_idx;
  assign state    = r_state;
  assign seq_wrap = r_seq_wrap;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed self-checking bench for rgb_fade_sequencer with STEP_DIV=8,
// FADE_STEPS=4, HOLD_STEPS=2, NUM_KEYS=8, gamma off.
module tb_rgb_fade_sequencer;

  logic       clk;
  logic       SW;
  logic       run;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [23:0] wr_data;
  logic [2:0] last_key;
  logic [7:0] red_val;
  logic [7:0] green_val;
  logic [7:0] blue_val;
  logic [2:0] key_idx;
  logic [1:0] state;
  logic       seq_wrap;

  int n_chk;
  int n_fail;

  rgb_fade_sequencer #(
    .CLK_FREQ_HZ(64),
    .STEP_HZ    (8),
    .NUM_KEYS   (8),
    .FADE_STEPS (4),
    .HOLD_STEPS (2)
  ) dut (
    .clk      (clk),
    .SW       (SW),
    .run      (run),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .last_key (last_key),
    .red_val  (red_val),
    .green_val(green_val),
    .blue_val (blue_val),
    .key_idx  (key_idx),
    .state    (state),
    .seq_wrap (seq_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checkpoints of the free-running sequence (cycles after the IDLE->FADE edge).
  localparam int NCP = 17;
  int         cp_c   [NCP] = '{7, 8, 16, 24, 32, 47, 48, 56, 64, 72, 80, 96, 104, 128, 143, 144, 152};
  logic [23:0] cp_rgb [NCP] = '{24'h000000, 24'h3F0000, 24'h7F0000, 24'hBF0000, 24'hFF0000,
                                24'hFF0000, 24'hFF0000, 24'hBF3F00, 24'h7F7F00, 24'h3FBF00,
                                24'h00FF00, 24'h00FF00, 24'h00BF3F, 24'h0000FF, 24'h0000FF,
                                24'h0000FF, 24'h3F00BF};
  logic [1:0] cp_st  [NCP] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1,
                               2'd2, 2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd1};
  logic [2:0] cp_key [NCP] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1,
                               3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] rgb();
    return {red_val, green_val, blue_val};
  endfunction

  // Assert reset mid-cycle, check reset outputs, release away from an edge.
  task automatic do_reset();
    run   = 1'b0;
    wr_en = 1'b0;
    SW    = 1'b0;
    #2;
    chk("rst_rgb",  {8'h00, rgb()}, 32'h0);
    chk("rst_st",   {30'h0, state}, 32'd0);
    chk("rst_key",  {29'h0, key_idx}, 32'd0);
    chk("rst_wrap", {31'h0, seq_wrap}, 32'd0);
    @(negedge clk);
    SW = 1'b1;
  endtask

  // Start the sequence: leaves time at #1 after the IDLE->FADE edge.
  task automatic start_run();
    @(negedge clk);
    run = 1'b1;
    go(1);
  endtask

  initial begin
    int   cp_i;
    int   wraps;
    int   wrap_at;
    int   changes;
    logic [31:0] snap;

    n_chk    = 0;
    n_fail   = 0;
    SW       = 1'b0;
    run      = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 3'd0;
    wr_data  = 24'h000000;
    last_key = 3'd2;
    #12;

    // Reset values, and IDLE is kept while run=0.
    do_reset();
    go(5);
    chk("idle_hold_st", {30'h0, state}, 32'd0);
    chk("idle_hold_rgb", {8'h00, rgb()}, 32'h0);

    // Full sequence: fades, holds, key order 0,1,2,0 and a single wrap pulse.
    start_run();
    chk("A_entry_st", {30'h0, state}, 32'd1);
    chk("A_entry_rgb", {8'h00, rgb()}, 32'h0);
    cp_i = 0; wraps = 0; wrap_at = -1;
    for (int c = 1; c <= 152; c++) begin
      go(1);
      if (seq_wrap) begin
        wraps++;
        wrap_at = c;
      end
      if (cp_i < NCP && c == cp_c[cp_i]) begin
        chk($sformatf("A_rgb@%0d", c), {8'h00, rgb()}, {8'h00, cp_rgb[cp_i]});
        chk($sformatf("A_st@%0d", c), {30'h0, state}, {30'h0, cp_st[cp_i]});
        chk($sformatf("A_key@%0d", c), {29'h0, key_idx}, {29'h0, cp_key[cp_i]});
        cp_i++;
      end
    end
    chk("A_wrap_count", wraps, 32'd1);
    chk("A_wrap_at", wrap_at, 32'd144);

    // Pause mid-fade after red=7F, three clocks into the next step period.
    do_reset();
    start_run();
    go(16);
    chk("P_pre_rgb", {8'h00, rgb()}, 32'h7F0000);
    go(3);
    run = 1'b0;
    snap = {3'h0, key_idx, state, rgb()};
    changes = 0;
    for (int c = 0; c < 50; c++) begin
      go(1);
      if ({3'h0, key_idx, state, rgb(), seq_wrap} != {snap, 1'b0}) changes++;
    end
    chk("P_changes", changes, 32'd0);
    chk("P_frozen_rgb", {8'h00, rgb()}, 32'h7F0000);
    chk("P_frozen_st", {30'h0, state}, 32'd1);
    run = 1'b1;
    go(4);
    chk("P_resume4_rgb", {8'h00, rgb()}, 32'h7F0000);
    go(1);
    chk("P_resume5_rgb", {8'h00, rgb()}, 32'hBF0000);

    // Write during fade does not disturb the current target; next fade uses it.
    do_reset();
    start_run();
    go(4);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 24'h123456;
    go(1);
    wr_en = 1'b0;
    go(27);
    chk("W_fade_end_rgb", {8'h00, rgb()}, 32'hFF0000);
    chk("W_fade_end_st", {30'h0, state}, 32'd2);
    go(24);
    chk("W_next_step1", {8'h00, rgb()}, 32'hC30D15);
    go(24);
    chk("W_next_end", {8'h00, rgb()}, 32'h123456);
    chk("W_next_key", {29'h0, key_idx}, 32'd1);

    // Write to addr 1 in the very cycle key1 is latched: old value is used.
    do_reset();
    last_key = 3'd1;
    start_run();
    go(47);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 24'h123456;
    go(1);
    wr_en = 1'b0;
    chk("L_latch_key", {29'h0, key_idx}, 32'd1);
    go(8);
    chk("L_old_step1", {8'h00, rgb()}, 32'hBF3F00);
    go(24);
    chk("L_old_end", {8'h00, rgb()}, 32'h00FF00);
    go(16);
    chk("L_wrap_key", {29'h0, key_idx}, 32'd0);
    chk("L_wrap_pulse", {31'h0, seq_wrap}, 32'd1);
    go(80);
    chk("L_new_end", {8'h00, rgb()}, 32'h123456);
    chk("L_new_st", {30'h0, state}, 32'd2);
    last_key = 3'd2;

    // Asynchronous reset mid-fade restores outputs and the table.
    do_reset();
    start_run();
    go(10);
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 24'h0A0B0C;
    go(1);
    wr_en = 1'b0;
    go(13);
    chk("R_pre_rgb", {8'h00, rgb()}, 32'hBF0000);
    #3;
    SW = 1'b0;
    #1;
    chk("R_async_rgb", {8'h00, rgb()}, 32'h0);
    chk("R_async_st", {30'h0, state}, 32'd0);
    chk("R_async_key", {29'h0, key_idx}, 32'd0);
    run = 1'b0;
    @(negedge clk);
    SW = 1'b1;
    start_run();
    go(8);
    chk("R_table_step1", {8'h00, rgb()}, 32'h3F0000);
    go(24);
    chk("R_table_end", {8'h00, rgb()}, 32'hFF0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
